floating_point_multiplier: RTL and testbench

- IEEE-754 binary64 multiplier with the same stb/ack operand and result handshake as the team's floating-point adder.
- Sits directly upstream of the adder in the Halley square-root datapath.
- Its PRODUCT output connects to the adder's A/A_stb/A_ack inputs, e.g. x*x feeding x*x + 3a.
- Multi-cycle FSM, one operation in flight, round-to-nearest-even only.

---
 rtl/fp64_pkg.sv | 39 +++
 rtl/fp64_unpack.sv | 39 +++
 rtl/floating_point_multiplier.sv | 235 +++++++++++++++++++++++
 tb/tb_floating_point_multiplier.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp64_pkg.sv
// Shared binary64 definitions for the floating-point multiplier and adder:
// field widths, special encodings, the multiplier state enum and the
// unpacked-operand struct produced by fp64_unpack.
package fp64_pkg;

    localparam int EXP_BIAS = 1023;
    localparam int EXP_W    = 11;
    localparam int MANT_W   = 52;

    localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] FP64_INF  = 64'h7FF0_0000_0000_0000;

    // Exponents are carried as 13-bit signed values with the bias removed.
    localparam logic signed [12:0] EXP_BIAS_S = 13'(EXP_BIAS);
    localparam logic signed [12:0] EXP_MIN    = -13'sd1022;
    localparam logic signed [12:0] EXP_INF_B  = 13'sd2047;

    typedef enum logic [3:0] {
        Store_a,
        Store_b,
        Unpack,
        Special_Case,
        Multiply,
        Normalize,
        Round,
        Pack,
        Product_Output
    } fpm_state_t;

    typedef struct packed {
        logic               sign;
        logic signed [12:0] exp;
        logic [52:0]        mant;
        logic               is_nan;
        logic               is_inf;
        logic               is_zero;
    } fp64_unpacked_t;

endpackage

// File: rtl/fp64_unpack.sv
// Combinational binary64 unpacker: splits a word into sign, unbiased
// exponent and 53-bit mantissa (hidden bit prepended) and classifies it.
// With FPM_SUBNORMAL_EN defined, subnormals keep their value (exponent -1022,
// no hidden bit); otherwise any zero exponent field is classified as zero.
module fp64_unpack
    import fp64_pkg::*;
(
    input  logic [63:0]    value,
    output fp64_unpacked_t unpacked
);

    logic [EXP_W-1:0]  exp_field;
    logic [MANT_W-1:0] frac;

    assign exp_field = value[62 -: EXP_W];
    assign frac      = value[MANT_W-1:0];

    // Field split and classification.
    always_comb begin
        unpacked.sign   = value[63];
        unpacked.is_nan = (exp_field == 11'h7FF) && (frac != '0);
        unpacked.is_inf = (exp_field == 11'h7FF) && (frac == '0);
`ifdef FPM_SUBNORMAL_EN
        unpacked.is_zero = (exp_field == '0) && (frac == '0);
        if (exp_field == '0) begin
            unpacked.exp  = EXP_MIN;
            unpacked.mant = {1'b0, frac};
        end else begin
            unpacked.exp  = $signed({2'b00, exp_field}) - EXP_BIAS_S;
            unpacked.mant = {1'b1, frac};
        end
`else
        unpacked.is_zero = (exp_field == '0);
        unpacked.exp     = $signed({2'b00, exp_field}) - EXP_BIAS_S;
        unpacked.mant    = {(exp_field != '0), frac};
`endif
    end

endmodule

// File: rtl/floating_point_multiplier.sv
// IEEE-754 binary64 multiplier, round-to-nearest-even, one operation in flight.
// Handshake: a word moves on a rising edge where *_stb && *_ack are both high.
// A_ack/B_ack are registered and rise one cycle after entering their store
// state; PRODUCT_stb holds PRODUCT stable until an edge with PRODUCT_ack high.
// MUL_CYCLES (1..4) sets the cycles spent in Multiply so the 53x53 product
// can be constrained as a multicycle path.
// Optional macro FPM_SUBNORMAL_EN: full subnormal support (variable latency);
// undefined, subnormal inputs and sub-normal results become signed zero.
module floating_point_multiplier
    import fp64_pkg::*;
#(
    parameter int MUL_CYCLES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [63:0] A,
    input  logic        A_stb,
    output logic        A_ack,
    input  logic [63:0] B,
    input  logic        B_stb,
    output logic        B_ack,
    output logic [63:0] PRODUCT,
    output logic        PRODUCT_stb,
    input  logic        PRODUCT_ack
);

    localparam logic [1:0] MUL_LAST = 2'(MUL_CYCLES - 1);

    fpm_state_t         state, next_state;
    logic [63:0]        a_reg, b_reg;
    fp64_unpacked_t     ua_w, ub_w, ua_r, ub_r;
    logic               z_sign;
    logic signed [12:0] z_exp;
    logic [105:0]       prod;
    logic [52:0]        z_mant;
    logic               guard_bit, round_bit, sticky_bit;
    logic [1:0]         mul_cnt;
    logic               a_ack_r, b_ack_r, product_stb_r;
    logic [63:0]        product_r;
    logic               is_special;
    logic [63:0]        special_val;
    logic               norm_done;
    logic               round_up;
    logic [53:0]        mant_inc;
    logic signed [12:0] biased;
    logic [63:0]        pack_val;

    fp64_unpack u_unpack_a (.value(a_reg), .unpacked(ua_w));
    fp64_unpack u_unpack_b (.value(b_reg), .unpacked(ub_w));

    assign z_sign      = ua_r.sign ^ ub_r.sign;
    assign A_ack       = a_ack_r;
    assign B_ack       = b_ack_r;
    assign PRODUCT     = product_r;
    assign PRODUCT_stb = product_stb_r;

    // Special-operand detection in priority order: NaN, Inf*0, Inf, zero.
    always_comb begin
        is_special  = 1'b1;
        special_val = '0;
        if (ua_r.is_nan || ub_r.is_nan)
            special_val = FP64_QNAN;
        else if ((ua_r.is_inf && ub_r.is_zero) || (ua_r.is_zero && ub_r.is_inf))
            special_val = FP64_QNAN;
        else if (ua_r.is_inf || ub_r.is_inf)
            special_val = {z_sign, FP64_INF[62:0]};
        else if (ua_r.is_zero || ub_r.is_zero)
            special_val = {z_sign, 63'b0};
        else
            is_special = 1'b0;
    end

`ifdef FPM_SUBNORMAL_EN
    // Normalize loops until the leading one reaches bit 105 (or the exponent
    // floor) and any result below the floor has been shifted up to it.
    assign norm_done = !((!prod[105] && (z_exp > EXP_MIN)) || (z_exp < EXP_MIN));
`else
    assign norm_done = 1'b1;
`endif

    // Round-to-nearest-even decision and incremented mantissa.
    always_comb begin
        round_up = guard_bit && (round_bit || sticky_bit || z_mant[0]);
        mant_inc = {1'b0, z_mant} + 54'd1;
    end

    // Final encoding: overflow to infinity, tiny results per build option.
    always_comb begin
        biased = z_exp + EXP_BIAS_S;
        if (biased >= EXP_INF_B)
            pack_val = {z_sign, FP64_INF[62:0]};
`ifdef FPM_SUBNORMAL_EN
        else if (!z_mant[52])
            pack_val = {z_sign, 11'd0, z_mant[51:0]};
`else
        else if (biased <= 13'sd0)
            pack_val = {z_sign, 63'b0};
`endif
        else
            pack_val = {z_sign, biased[10:0], z_mant[51:0]};
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) state <= Store_a;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            Store_a:        if (A_stb && a_ack_r) next_state = Store_b;
            Store_b:        if (B_stb && b_ack_r) next_state = Unpack;
            Unpack:         next_state = Special_Case;
            Special_Case:   next_state = is_special ? Product_Output : Multiply;
            Multiply:       if (mul_cnt == MUL_LAST) next_state = Normalize;
            Normalize:      if (norm_done) next_state = Round;
            Round:          next_state = Pack;
            Pack:           next_state = Product_Output;
            Product_Output: if (PRODUCT_ack) next_state = Store_a;
            default:        next_state = Store_a;
        endcase
    end

    // Datapath registers and registered handshake outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_reg         <= '0;
            b_reg         <= '0;
            ua_r          <= '0;
            ub_r          <= '0;
            z_exp         <= '0;
            prod          <= '0;
            z_mant        <= '0;
            guard_bit     <= 1'b0;
            round_bit     <= 1'b0;
            sticky_bit    <= 1'b0;
            mul_cnt       <= '0;
            a_ack_r       <= 1'b0;
            b_ack_r       <= 1'b0;
            product_stb_r <= 1'b0;
            product_r     <= '0;
        end else begin
            mul_cnt <= '0;
            case (state)
                Store_a: begin
                    if (A_stb && a_ack_r) begin
                        a_reg   <= A;
                        a_ack_r <= 1'b0;
                    end else begin
                        a_ack_r <= 1'b1;
                    end
                end
                Store_b: begin
                    if (B_stb && b_ack_r) begin
                        b_reg   <= B;
                        b_ack_r <= 1'b0;
                    end else begin
                        b_ack_r <= 1'b1;
                    end
                end
                Unpack: begin
                    ua_r <= ua_w;
                    ub_r <= ub_w;
                end
                Special_Case: begin
                    if (is_special) begin
                        product_r     <= special_val;
                        product_stb_r <= 1'b1;
                    end
                end
                Multiply: begin
                    // Operands are stable for the whole stay, so the product
                    // only has to settle by the last Multiply cycle.
                    prod    <= {53'b0, ua_r.mant} * {53'b0, ub_r.mant};
                    z_exp   <= ua_r.exp + ub_r.exp + 13'sd1;
                    mul_cnt <= mul_cnt + 2'd1;
                end
                Normalize: begin
`ifdef FPM_SUBNORMAL_EN
                    if (!prod[105] && (z_exp > EXP_MIN)) begin
                        prod  <= {prod[104:0], 1'b0};
                        z_exp <= z_exp - 13'sd1;
                    end else if (z_exp < EXP_MIN - 13'sd54) begin
                        // Far below the subnormal range: only stickiness survives.
                        prod  <= {105'b0, (prod != '0)};
                        z_exp <= EXP_MIN;
                    end else if (z_exp < EXP_MIN) begin
                        prod  <= {1'b0, prod[105:2], prod[1] | prod[0]};
                        z_exp <= z_exp + 13'sd1;
                    end else begin
                        z_mant     <= prod[105:53];
                        guard_bit  <= prod[52];
                        round_bit  <= prod[51];
                        sticky_bit <= (prod[50:0] != '0);
                    end
`else
                    if (prod[105]) begin
                        z_mant     <= prod[105:53];
                        guard_bit  <= prod[52];
                        round_bit  <= prod[51];
                        sticky_bit <= (prod[50:0] != '0);
                    end else begin
                        z_mant     <= prod[104:52];
                        guard_bit  <= prod[51];
                        round_bit  <= prod[50];
                        sticky_bit <= (prod[49:0] != '0);
                        z_exp      <= z_exp - 13'sd1;
                    end
`endif
                end
                Round: begin
                    if (round_up) begin
                        if (mant_inc[53]) begin
                            z_mant <= mant_inc[53:1];
                            z_exp  <= z_exp + 13'sd1;
                        end else begin
                            z_mant <= mant_inc[52:0];
                        end
                    end
                end
                Pack: begin
                    product_r     <= pack_val;
                    product_stb_r <= 1'b1;
                end
                Product_Output: begin
                    if (PRODUCT_ack) product_stb_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_multiplier.sv
// Bench for floating_point_multiplier in its default build (MUL_CYCLES = 1,
// subnormals flushed). Expected products come from host double arithmetic
// plus the block's special-value and flush rules.
module tb_floating_point_multiplier;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] INF  = 64'h7FF0_0000_0000_0000;
    localparam int NORM_LAT = 6;
    localparam int SPEC_LAT = 2;

    logic        Clock;
    logic        Reset;
    logic [63:0] A;
    logic        A_stb;
    logic        A_ack;
    logic [63:0] B;
    logic        B_stb;
    logic        B_ack;
    logic [63:0] PRODUCT;
    logic        PRODUCT_stb;
    logic        PRODUCT_ack;

    int total;
    int bad;
    logic [63:0] exp_q[$];
    int          lat_q[$];

    floating_point_multiplier #(.MUL_CYCLES(1)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .A          (A),
        .A_stb      (A_stb),
        .A_ack      (A_ack),
        .B          (B),
        .B_stb      (B_stb),
        .B_ack      (B_ack),
        .PRODUCT    (PRODUCT),
        .PRODUCT_stb(PRODUCT_stb),
        .PRODUCT_ack(PRODUCT_ack)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        logic [63:0] r;
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
        a_zero = (a[62:52] == 0);
        b_zero = (b[62:52] == 0);
        s      = a[63] ^ b[63];
        if (a_nan || b_nan) return QNAN;
        if ((a_inf && b_zero) || (a_zero && b_inf)) return QNAN;
        if (a_inf || b_inf) return {s, INF[62:0]};
        if (a_zero || b_zero) return {s, 63'b0};
        r = $realtobits($bitstoreal(a) * $bitstoreal(b));
        if (r[62:52] == 0) r = {r[63], 63'b0};
        return r;
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b);
        if (a[62:52] == 0 || a[62:52] == 11'h7FF || b[62:52] == 0 || b[62:52] == 11'h7FF)
            return SPEC_LAT;
        return NORM_LAT;
    endfunction

    function automatic logic [63:0] gen_operand();
        logic [63:0] rnd;
        logic [10:0] e;
        logic [51:0] f;
        int cls;
        rnd = {$urandom(), $urandom()};
        f   = rnd[51:0];
        cls = $urandom_range(0, 13);
        case (cls)
            0:       begin e = 11'd0; f = '0; end
            1:       begin e = 11'd0; f[0] = 1'b1; end
            2:       begin e = 11'h7FF; f = '0; end
            3:       begin e = 11'h7FF; f[0] = 1'b1; end
            4:       e = 11'($urandom_range(1900, 2046));
            5:       e = 11'($urandom_range(1, 150));
            6:       begin e = 11'($urandom_range(900, 1100)); f = '1; end
            default: e = 11'($urandom_range(823, 1223));
        endcase
        return {rnd[63], e, f};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic xfer_ab(input logic [63:0] a, input logic [63:0] b);
        int n;
        @(negedge Clock);
        A = a;
        A_stb = 1'b1;
        n = 0;
        while (!A_ack && n < 40) begin
            @(negedge Clock);
            n++;
        end
        total++;
        if (A_ack !== 1'b1) begin
            bad++;
            $display("FAIL a_handshake: A_ack=%b required 1 within 40 cycles", A_ack);
        end
        @(posedge Clock);
        #1;
        A_stb = 1'b0;
        B = b;
        B_stb = 1'b1;
        @(negedge Clock);
        n = 0;
        while (!B_ack && n < 40) begin
            @(negedge Clock);
            n++;
        end
        total++;
        if (B_ack !== 1'b1) begin
            bad++;
            $display("FAIL b_handshake: B_ack=%b required 1 within 40 cycles", B_ack);
        end
        @(posedge Clock);
        #1;
        B_stb = 1'b0;
    endtask

    // Returns the edge number (B transfer = 0) at which PRODUCT_stb was seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge Clock);
            #1;
            lat++;
        end while (!PRODUCT_stb && lat < 80);
        total++;
        if (PRODUCT_stb !== 1'b1) begin
            bad++;
            $display("FAIL result_timeout: PRODUCT_stb=%b required 1 within 80 cycles", PRODUCT_stb);
        end
    endtask

    task automatic accept(input int hold);
        repeat (hold) begin
            @(posedge Clock);
            #1;
        end
        PRODUCT_ack = 1'b1;
        @(posedge Clock);
        #1;
        PRODUCT_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        total++;
        if (A_ack !== 1'b0) begin bad++; $display("FAIL reset_a_ack: got %b required 0", A_ack); end
        total++;
        if (B_ack !== 1'b0) begin bad++; $display("FAIL reset_b_ack: got %b required 0", B_ack); end
        total++;
        if (PRODUCT_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b required 0", PRODUCT_stb); end
        total++;
        if (PRODUCT !== 64'h0) begin bad++; $display("FAIL reset_product: got %h required 0", PRODUCT); end
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        total++;
        if (A_ack !== 1'b1) begin bad++; $display("FAIL reset_release_a_ack: got %b required 1", A_ack); end
        total++;
        if (B_ack !== 1'b0) begin bad++; $display("FAIL reset_release_b_ack: got %b required 0", B_ack); end
    endtask

    task automatic test_directed();
        logic [63:0] ta[11];
        logic [63:0] tb[11];
        logic [63:0] te[11];
        int          tl[11];
        int lat;
        ta[0]  = 64'h4000_0000_0000_0000; tb[0]  = 64'h4008_0000_0000_0000; te[0]  = 64'h4018_0000_0000_0000; tl[0]  = NORM_LAT;
        ta[1]  = 64'h3FF8_0000_0000_0000; tb[1]  = 64'hC004_0000_0000_0000; te[1]  = 64'hC00E_0000_0000_0000; tl[1]  = NORM_LAT;
        ta[2]  = 64'h3FF0_0000_0000_0001; tb[2]  = 64'h3FF0_0000_0000_0001; te[2]  = 64'h3FF0_0000_0000_0002; tl[2]  = NORM_LAT;
        ta[3]  = 64'h7FF0_0000_0000_0000; tb[3]  = 64'h0000_0000_0000_0000; te[3]  = QNAN;                   tl[3]  = SPEC_LAT;
        ta[4]  = 64'h7FEF_FFFF_FFFF_FFFF; tb[4]  = 64'h4000_0000_0000_0000; te[4]  = 64'h7FF0_0000_0000_0000; tl[4]  = NORM_LAT;
        ta[5]  = 64'hFFF4_0000_0000_0000; tb[5]  = 64'h3FF0_0000_0000_0000; te[5]  = QNAN;                   tl[5]  = SPEC_LAT;
        ta[6]  = 64'h8000_0000_0000_0000; tb[6]  = 64'h4014_0000_0000_0000; te[6]  = 64'h8000_0000_0000_0000; tl[6]  = SPEC_LAT;
        ta[7]  = 64'hFFF0_0000_0000_0000; tb[7]  = 64'h4008_0000_0000_0000; te[7]  = 64'hFFF0_0000_0000_0000; tl[7]  = SPEC_LAT;
        ta[8]  = 64'h0000_0000_0000_0001; tb[8]  = 64'hC000_0000_0000_0000; te[8]  = 64'h8000_0000_0000_0000; tl[8]  = SPEC_LAT;
        ta[9]  = 64'h0010_0000_0000_0000; tb[9]  = 64'h3FE0_0000_0000_0000; te[9]  = 64'h0000_0000_0000_0000; tl[9]  = NORM_LAT;
        ta[10] = 64'h3FF0_0000_0000_0001; tb[10] = 64'h3FF8_0000_0000_0000; te[10] = 64'h3FF8_0000_0000_0002; tl[10] = NORM_LAT;
        for (int i = 0; i < 11; i++) begin
            xfer_ab(ta[i], tb[i]);
            wait_result(lat);
            total++;
            if (lat != tl[i]) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got edge %0d required %0d", i, lat, tl[i]);
            end
            total++;
            if (PRODUCT !== te[i]) begin
                bad++;
                $display("FAIL dir_product[%0d]: %h * %h got %h required %h", i, ta[i], tb[i], PRODUCT, te[i]);
            end
            accept(0);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        xfer_ab(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        wait_result(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            total++;
            if (PRODUCT_stb !== 1'b1 || PRODUCT !== 64'h4018_0000_0000_0000 || A_ack !== 1'b0) begin
                bad++;
                $display("FAIL hold[%0d]: stb=%b product=%h a_ack=%b required 1/4018000000000000/0",
                         i, PRODUCT_stb, PRODUCT, A_ack);
            end
        end
        PRODUCT_ack = 1'b1;
        @(posedge Clock);
        #1;
        PRODUCT_ack = 1'b0;
        total++;
        if (PRODUCT_stb !== 1'b0) begin bad++; $display("FAIL ack_drop_stb: got %b required 0", PRODUCT_stb); end
        total++;
        if (A_ack !== 1'b0) begin bad++; $display("FAIL ack_drop_a_ack: got %b required 0", A_ack); end
        @(posedge Clock);
        #1;
        total++;
        if (A_ack !== 1'b1) begin bad++; $display("FAIL ack_rearm_a_ack: got %b required 1", A_ack); end
        // An ack with no result pending must not disturb the idle block.
        PRODUCT_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock);
            #1;
            total++;
            if (PRODUCT_stb !== 1'b0 || A_ack !== 1'b1) begin
                bad++;
                $display("FAIL idle_ack[%0d]: stb=%b a_ack=%b required 0/1", i, PRODUCT_stb, A_ack);
            end
        end
        PRODUCT_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        xfer_ab(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        total++;
        if (A_ack !== 1'b0 || B_ack !== 1'b0 || PRODUCT_stb !== 1'b0 || PRODUCT !== 64'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs: a_ack=%b b_ack=%b stb=%b product=%h required all 0",
                     A_ack, B_ack, PRODUCT_stb, PRODUCT);
        end
        Reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(posedge Clock);
            #1;
            if (PRODUCT_stb) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL mid_reset_stale_stb: got %b required 0", seen); end
        xfer_ab(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000);
        wait_result(lat);
        total++;
        if (lat != NORM_LAT) begin bad++; $display("FAIL post_reset_latency: got %0d required %0d", lat, NORM_LAT); end
        total++;
        if (PRODUCT !== 64'h4018_0000_0000_0000) begin
            bad++;
            $display("FAIL post_reset_product: got %h required 4018000000000000", PRODUCT);
        end
        accept(0);
    endtask

    task automatic test_random();
        logic [63:0] a, b, got, want;
        int lat, want_lat;
        for (int i = 0; i < 150; i++) begin
            a = gen_operand();
            b = gen_operand();
            exp_q.push_back(ref_mul(a, b));
            lat_q.push_back(ref_lat(a, b));
            xfer_ab(a, b);
            wait_result(lat);
            got = PRODUCT;
            want = exp_q.pop_front();
            want_lat = lat_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rand_product[%0d]: %h * %h got %h required %h", i, a, b, got, want);
            end
            total++;
            if (lat != want_lat) begin
                bad++;
                $display("FAIL rand_latency[%0d]: %h * %h got edge %0d required %0d", i, a, b, lat, want_lat);
            end
            accept($urandom_range(0, 3));
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        total = 0;
        bad = 0;
        Reset = 1'b1;
        A = '0;
        B = '0;
        A_stb = 1'b0;
        B_stb = 1'b0;
        PRODUCT_ack = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
